// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: precharge, wordline/column-mux activation, optional
// sense, then a one-cycle done pulse. All outputs are registered.
module sram_access_ctrl #(
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [15:0] rdata,
  output logic        pre_en,
  output logic        wl_en,
  output logic [7:0]  row_addr,
  output logic [7:0]  col_sel,
  output logic        write_en,
  output logic        sae,
  output logic [15:0] din_drv,
  input  logic [15:0] sa_out
);

  typedef enum logic [2:0] {IDLE, PRE, ACT, SENSE, DONE} state_t;

  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
  localparam logic [3:0] WL_LOAD  = 4'(WL_CYC - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  col_q;
  logic [15:0] wdata_q;

  // Outputs are assigned on the transition into the state that owns them,
  // so each output register already holds the value for the coming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      col_q    <= 3'd0;
      wdata_q  <= 16'd0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rdata    <= 16'd0;
      pre_en   <= 1'b0;
      wl_en    <= 1'b0;
      row_addr <= 8'd0;
      col_sel  <= 8'd0;
      write_en <= 1'b0;
      sae      <= 1'b0;
      din_drv  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= PRE;
            cnt      <= PRE_LOAD;
            we_q     <= we;
            col_q    <= addr[2:0];
            wdata_q  <= wdata;
            row_addr <= addr[10:3];
            ready    <= 1'b0;
            pre_en   <= 1'b1;
          end
        end
        PRE: begin
          if (cnt == 4'd0) begin
            state    <= ACT;
            cnt      <= WL_LOAD;
            pre_en   <= 1'b0;
            wl_en    <= 1'b1;
            col_sel  <= 8'd1 << col_q;
            write_en <= we_q;
            din_drv  <= we_q ? wdata_q : 16'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACT: begin
          if (cnt == 4'd0) begin
            wl_en    <= 1'b0;
            write_en <= 1'b0;
            din_drv  <= 16'd0;
            if (we_q) begin
              state   <= DONE;
              col_sel <= 8'd0;
              done    <= 1'b1;
            end else begin
              // col_sel stays up so the sense amps see the selected column
              state <= SENSE;
              sae   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SENSE: begin
          state   <= DONE;
          sae     <= 1'b0;
          col_sel <= 8'd0;
          rdata   <= sa_out;
          done    <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          ready    <= 1'b1;
          row_addr <= 8'd0;
        end
        default: begin
          state    <= IDLE;
          ready    <= 1'b1;
          done     <= 1'b0;
          pre_en   <= 1'b0;
          wl_en    <= 1'b0;
          row_addr <= 8'd0;
          col_sel  <= 8'd0;
          write_en <= 1'b0;
          sae      <= 1'b0;
          din_drv  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (default and PRE=3/WL=4) share the
// inputs; a cycle-position model predicts every output, plus directed pins.
module tb_sram_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [10:0] addr;
  logic [15:0] wdata, sa_out;

  logic        readyO [2];
  logic        doneO  [2];
  logic        preO   [2];
  logic        wlO    [2];
  logic        weO    [2];
  logic        saeO   [2];
  logic [15:0] rdataO [2];
  logic [15:0] dinO   [2];
  logic [7:0]  rowO   [2];
  logic [7:0]  colO   [2];

  sram_access_ctrl d0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(readyO[0]), .done(doneO[0]), .rdata(rdataO[0]), .pre_en(preO[0]),
    .wl_en(wlO[0]), .row_addr(rowO[0]), .col_sel(colO[0]), .write_en(weO[0]),
    .sae(saeO[0]), .din_drv(dinO[0]), .sa_out(sa_out)
  );

  sram_access_ctrl #(.PRE_CYC(3), .WL_CYC(4)) d1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(readyO[1]), .done(doneO[1]), .rdata(rdataO[1]), .pre_en(preO[1]),
    .wl_en(wlO[1]), .row_addr(rowO[1]), .col_sel(colO[1]), .write_en(weO[1]),
    .sae(saeO[1]), .din_drv(dinO[1]), .sa_out(sa_out)
  );

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;
  int P [2] = '{1, 3};
  int W [2] = '{2, 4};

  // Model: k is the cycle number within an access, 1 being the cycle after accept.
  bit          mBusy  [2];
  int          mK     [2];
  logic        mWe    [2];
  logic [10:0] mAddr  [2];
  logic [15:0] mWdata [2];
  logic [15:0] mRdata [2];

  function automatic int doneAt(int d);
    return P[d] + W[d] + (mWe[d] ? 1 : 2);
  endfunction

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s dut%0d got=%0h want=%0h at %0t", name, d, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mBusy[d] = 1'b0;
        mK[d] = 0;
        mWe[d] = 1'b0;
        mAddr[d] = 11'd0;
        mWdata[d] = 16'd0;
        mRdata[d] = 16'd0;
      end else if (!mBusy[d]) begin
        if (req === 1'b1) begin
          mBusy[d] = 1'b1;
          mK[d] = 1;
          mWe[d] = we;
          mAddr[d] = addr;
          mWdata[d] = wdata;
        end
      end else begin
        if (!mWe[d] && mK[d] == P[d] + W[d] + 1) mRdata[d] = sa_out;
        mK[d]++;
        if (mK[d] > doneAt(d)) mBusy[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        automatic bit act = mBusy[d] && mK[d] > P[d] && mK[d] <= P[d] + W[d];
        automatic bit sense = mBusy[d] && !mWe[d] && mK[d] == P[d] + W[d] + 1;
        automatic logic [7:0] expCol = (act || sense) ? (8'd1 << mAddr[d][2:0]) : 8'd0;
        checkOutput("ready", d, 32'(readyO[d]), 32'(!mBusy[d]));
        checkOutput("done", d, 32'(doneO[d]), 32'(mBusy[d] && mK[d] == doneAt(d)));
        checkOutput("pre_en", d, 32'(preO[d]), 32'(mBusy[d] && mK[d] <= P[d]));
        checkOutput("wl_en", d, 32'(wlO[d]), 32'(act));
        checkOutput("col_sel", d, 32'(colO[d]), 32'(expCol));
        checkOutput("write_en", d, 32'(weO[d]), 32'(act && mWe[d]));
        checkOutput("sae", d, 32'(saeO[d]), 32'(sense));
        checkOutput("din_drv", d, 32'(dinO[d]), 32'((act && mWe[d]) ? mWdata[d] : 16'd0));
        checkOutput("row_addr", d, 32'(rowO[d]), 32'(mBusy[d] ? mAddr[d][10:3] : 8'd0));
        checkOutput("rdata", d, 32'(rdataO[d]), 32'(mRdata[d]));
        checkOutput("inv_pre_wl", d, 32'(preO[d] && wlO[d]), 32'd0);
        checkOutput("inv_we_col", d, 32'(weO[d] && colO[d] == 8'd0), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic q, input logic w,
                               input logic [10:0] a, input logic [15:0] wd,
                               input logic [15:0] sa);
    rst = r; req = q; we = w; addr = a; wdata = wd; sa_out = sa;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int preCnt, wlCnt, saeCnt, weCnt, lat0, lat1, doneCnt;
    logic [15:0] rdAtDone;
    int readyAt [$];

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 11'd0; wdata = 16'd0; sa_out = 16'd0;
    @(posedge clk);
    #1;
    checking = 1'b1;

    // Read at 0x2A5 with default timing and with PRE=3/WL=4
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h2A5, 16'h0000, 16'hBEEF);
    req = 1'b0;
    preCnt = 0; wlCnt = 0; saeCnt = 0; lat0 = 0; lat1 = 0; rdAtDone = 16'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (preO[0]) preCnt++;
      if (wlO[0] && rowO[0] == 8'h54 && colO[0] == 8'h20) wlCnt++;
      if (saeO[0]) saeCnt++;
      if (doneO[0]) begin lat0 = c; rdAtDone = rdataO[0]; end
      if (doneO[1]) lat1 = c;
    end
    checkOutput("read_pre_cycles", 0, preCnt, 1);
    checkOutput("read_wl_cycles", 0, wlCnt, 2);
    checkOutput("read_sae_cycles", 0, saeCnt, 1);
    checkOutput("read_done_latency", 0, lat0, 5);
    checkOutput("read_rdata", 0, 32'(rdAtDone), 32'hBEEF);
    checkOutput("read_done_latency_p3w4", 1, lat1, 9);

    // Write 0x1234 to addr 0x007
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h007, 16'h1234, 16'h0);
    req = 1'b0;
    weCnt = 0; saeCnt = 0; lat0 = 0; lat1 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (weO[0] && dinO[0] == 16'h1234 && colO[0] == 8'h80) weCnt++;
      if (saeO[0]) saeCnt++;
      if (doneO[0]) lat0 = c;
      if (doneO[1]) lat1 = c;
    end
    checkOutput("write_drive_cycles", 0, weCnt, 2);
    checkOutput("write_sae_cycles", 0, saeCnt, 0);
    checkOutput("write_done_latency", 0, lat0, 4);
    checkOutput("write_done_latency_p3w4", 1, lat1, 8);

    // req held high: accepts must land every 6 cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h13C, 16'h0, 16'h5A5A);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (readyO[0]) readyAt.push_back(c);
      addr = 11'($urandom);
      sa_out = 16'($urandom);
    end
    req = 1'b0;
    checkOutput("b2b_idle_count", 0, readyAt.size(), 3);
    for (int i = 0; i < readyAt.size() && i < 3; i++)
      checkOutput("b2b_idle_cycle", 0, readyAt[i], 6 * (i + 1));

    // Reset during write ACT
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h155, 16'hA5A5, 16'h0);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_in_act", 0, 32'(weO[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", 0, 32'(readyO[0]), 32'd1);
    checkOutput("abort_din", 0, 32'(dinO[0]), 32'd0);
    checkOutput("abort_rdata", 0, 32'(rdataO[0]), 32'd0);
    doneCnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (doneO[0] || doneO[1]) doneCnt++;
    end
    checkOutput("abort_no_done", 0, doneCnt, 0);

    // rst and req together: no accept
    applyStimulus(1'b1, 1'b1, 1'b0, 11'h2A5, 16'h0, 16'h0);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    checkOutput("rst_prio_ready", 0, 32'(readyO[0]), 32'd1);
    checkOutput("rst_prio_pre", 0, 32'(preO[0]), 32'd0);

    // Randomized traffic with X on unaccepted inputs and occasional resets
    for (int i = 0; i < 3000; i++) begin
      automatic logic r = ($urandom_range(0, 99) == 0);
      automatic logic q = 1'($urandom_range(0, 1));
      if (q || $urandom_range(0, 3) != 0)
        applyStimulus(r, q, 1'($urandom), 11'($urandom), 16'($urandom), 16'($urandom));
      else
        applyStimulus(r, q, 1'bx, 11'bx, 16'bx, 16'($urandom));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter PRE_CYC, default 1, precharge duration in cycles (legal range 1..15).
REQ-002 SHALL have parameter WL_CYC, default 2, wordline-active duration in cycles (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 1 bit: access request.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; sampled at accept.
REQ-007 SHALL have port addr, input, 11 bits: [10:3] row, [2:0] column-mux select.
REQ-008 SHALL have port wdata, input, 16 bits: write data; sampled at accept.
REQ-009 SHALL have port ready, output, 1 bit: 1 only in IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 16 bits: read result; valid when done=1 for a read and held until the next read completes.
REQ-012 SHALL have port pre_en, output, 1 bit: bitline precharge.
REQ-013 SHALL have port wl_en, output, 1 bit: wordline enable.
REQ-014 SHALL have port row_addr, output, 8 bits: latched row.
REQ-015 SHALL have port col_sel, output, 8 bits: one-hot column transmission-gate select.
REQ-016 SHALL have port write_en, output, 1 bit: array-wide direction control for the column mux.
REQ-017 SHALL have port sae, output, 1 bit: sense-amp enable.
REQ-018 SHALL have port din_drv, output, 16 bits: write-driver data.
REQ-019 SHALL have port sa_out, input, 16 bits: sense-amp outputs.

Function
REQ-020 SHALL implement FSM states IDLE, PRE, ACT, SENSE, DONE.
REQ-021 SHALL accept a request on an edge where state=IDLE and req=1, and on that edge latch we, addr and wdata and enter PRE.
REQ-022 SHALL ignore req while ready=0, with no queuing.
REQ-023 SHALL hold PRE for exactly PRE_CYC cycles with pre_en=1, using a 4-bit down-counter, then enter ACT.
REQ-024 SHALL hold ACT for exactly WL_CYC cycles with wl_en=1 and col_sel=1<<addr[2:0].
REQ-025 SHALL drive write_en equal to the latched we during ACT only, constant throughout the state.
REQ-026 SHALL, from ACT, enter SENSE if the access is a read, otherwise enter DONE.
REQ-027 SHALL, in SENSE (1 cycle), drive sae=1, wl_en=0 and keep col_sel; rdata SHALL capture sa_out on the edge leaving SENSE.
REQ-028 SHALL, in DONE (1 cycle), drive done=1 and then return to IDLE.
REQ-029 SHALL produce done exactly PRE_CYC+WL_CYC+2 cycles after the accept edge for a read, and PRE_CYC+WL_CYC+1 cycles for a write.
REQ-030 SHALL, as an invariant, never assert pre_en and wl_en together.
REQ-031 SHALL, as an invariant, drive write_en=0 whenever col_sel=0.
REQ-032 SHALL drive col_sel=0 outside ACT and SENSE.
REQ-033 SHALL drive din_drv=latched wdata during write ACT and 0 otherwise, so the mux is never driven from both sides.
REQ-034 SHALL drive row_addr as a registered output held from accept until IDLE, and 0 in IDLE.
REQ-035 SHALL allow back-to-back operation: req held high is accepted on the first IDLE edge after DONE, giving a 1-cycle IDLE gap.
REQ-036 SHALL produce no X on outputs when we, addr or wdata is X while not being accepted.

Reset
REQ-037 SHALL, on rst=1 at an edge, set state=IDLE, clear counters, and drive ready=1, done=0, rdata=0, pre_en=0, wl_en=0, row_addr=0, col_sel=0, write_en=0, sae=0 and din_drv=0 on the next cycle.
REQ-038 SHALL, when reset occurs mid-access (any state), abort the access with no done pulse and leave rdata=0.
REQ-039 SHALL give rst priority over a simultaneous req.

Verification
REQ-040 SHALL be covered by: defaults, read at addr=0x2A5 -> pre_en 1 cycle, wl_en 2 cycles with row_addr=0x54 and col_sel=0x20, sae 1 cycle, done at accept+5, rdata=sa_out (e.g. 0xBEEF).
REQ-041 SHALL be covered by: defaults, write we=1, addr=0x007, wdata=0x1234 -> write_en=1 and din_drv=0x1234 for exactly 2 cycles with col_sel=0x80, no sae, done at accept+4.
REQ-042 SHALL be covered by: PRE_CYC=3, WL_CYC=4, read -> done at accept+9, with pre_en/wl_en/col_sel/write_en invariants checked every cycle.
REQ-043 SHALL be covered by: req held high across 3 accesses -> accepts spaced exactly 6 cycles (reads, defaults), extra req while busy ignored.
REQ-044 SHALL be covered by: rst asserted during ACT of a write -> next cycle all outputs at reset values, ready=1, no done.
REQ-045 SHALL be covered by: rst and req both 1 on the same edge -> no accept, state remains IDLE.
